// File: rtl/trigger_engine.sv
// Logic-analyser style trigger: per-channel edge/level qualifiers combined by AND/OR,
// arm/holdoff/fire FSM. Define TRIGGER_ENGINE_TIMESTAMP_EN to build the trig_time counter.
module trigger_engine #(
  parameter int CH_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_PLL,
  input  logic             reset,
  input  logic [CH_W-1:0]  data_in,
  input  logic             arm,
  input  logic             disarm,
  input  logic [CH_W-1:0]  rise_mask,
  input  logic [CH_W-1:0]  fall_mask,
  input  logic [CH_W-1:0]  level_mask,
  input  logic [CH_W-1:0]  level_val,
  input  logic             combine_and,
  input  logic [CNT_W-1:0] holdoff,
  output logic [CH_W-1:0]  data_out,
  output logic             armed,
  output logic             triggered,
  output logic             trig_latched,
  output logic [CNT_W-1:0] trig_time
);

  typedef enum logic [1:0] {IDLE, HOLDOFF, ARMED, FIRED} stateT;

  stateT            state, nextState;
  logic [CH_W-1:0]  cur, prev;
  logic             valid, prevValid;
  logic [CNT_W-1:0] holdCnt;
  logic             triggeredQ;
  logic             restart;
  logic             fire;
  logic             match;

  logic [CH_W-1:0]  riseHit, fallHit, levelHit;
  logic [CH_W-1:0]  edgeMask, chanEn, chanOk;

  // Sample pipeline. prevValid keeps the first post-reset sample from being
  // compared against the reset value of prev, which would look like an edge.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_PLL or posedge reset) begin
    if (reset) begin
      cur       <= '0;
      prev      <= '0;
      valid     <= 1'b0;
      prevValid <= 1'b0;
    end else begin
      prev      <= cur;
      cur       <= data_in;
      valid     <= 1'b1;
      prevValid <= valid;
    end
  end

  // Channel qualifiers and combine.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    riseHit  = '0;
    fallHit  = '0;
    if (valid && prevValid) begin
      riseHit = rise_mask & ~prev & cur;
      fallHit = fall_mask & prev & ~cur;
    end
    levelHit = level_mask & ~(cur ^ level_val);
    edgeMask = rise_mask | fall_mask;
    chanEn   = edgeMask | level_mask;
    chanOk   = (~edgeMask | riseHit | fallHit) & (~level_mask | levelHit);
    if (combine_and)
      match = (&(chanOk | ~chanEn)) && (|chanEn);
    else
      match = |(riseHit | fallHit | levelHit);
  end

  // FSM state register
  always_ff @(posedge clk_PLL or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // FSM next state: disarm beats arm, arm beats match.
  always_comb begin
    nextState = state;
    restart   = 1'b0;
    if (disarm) begin
      nextState = IDLE;
    end else if (arm) begin
      restart   = 1'b1;
      nextState = (holdoff == '0) ? ARMED : HOLDOFF;
    end else begin
      case (state)
        HOLDOFF: if (holdCnt <= CNT_W'(1)) nextState = ARMED;
        ARMED:   if (match) nextState = FIRED;
        default: nextState = state;
      endcase
    end
  end

  assign fire = (state == ARMED) && (nextState == FIRED);

  // FSM outputs
  always_comb begin
    armed        = (state == ARMED);
    trig_latched = (state == FIRED);
    triggered    = triggeredQ;
    data_out     = cur;
  end

  always_ff @(posedge clk_PLL or posedge reset) begin
    if (reset) begin
      holdCnt    <= '0;
      triggeredQ <= 1'b0;
    end else begin
      triggeredQ <= fire;
      if (restart)
        holdCnt <= holdoff;
      else if (state == HOLDOFF && holdCnt != '0)
        holdCnt <= holdCnt - CNT_W'(1);
    end
  end

`ifdef TRIGGER_ENGINE_TIMESTAMP_EN
  logic [CNT_W-1:0] armCnt, trigTimeQ;

  // Counts cycles spent in ARMED; restarts on every ARMED entry, saturates.
  always_ff @(posedge clk_PLL or posedge reset) begin
    if (reset) begin
      armCnt    <= '0;
      trigTimeQ <= '0;
    end else begin
      if (nextState == ARMED && (state != ARMED || restart))
        armCnt <= '0;
      else if (state == ARMED && armCnt != '1)
        armCnt <= armCnt + CNT_W'(1);
      if (fire)
        trigTimeQ <= armCnt;
    end
  end

  assign trig_time = trigTimeQ;
`else
  assign trig_time = '0;
`endif

endmodule

// File: tb/tb_trigger_engine.sv
// Directed bench for trigger_engine: edge/level/AND/OR matching, holdoff, disarm
// priority, async reset and (when TRIGGER_ENGINE_TIMESTAMP_EN is defined) trig_time.
module tb_trigger_engine;

`ifdef TRIGGER_ENGINE_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic        clk_PLL = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        arm, disarm;
  logic [7:0]  rise_mask, fall_mask, level_mask, level_val;
  logic        combine_and;
  logic [15:0] holdoff;
  logic [7:0]  data_out, dataOutS;
  logic        armed, triggered, trig_latched;
  logic        armedS, triggeredS, trigLatchedS;
  logic [15:0] trig_time;
  logic [3:0]  trigTimeS;

  int total = 0;
  int bad   = 0;

  trigger_engine #(.CH_W(8), .CNT_W(16)) dut (
    .clk_PLL(clk_PLL), .reset(reset), .data_in(data_in), .arm(arm), .disarm(disarm),
    .rise_mask(rise_mask), .fall_mask(fall_mask), .level_mask(level_mask),
    .level_val(level_val), .combine_and(combine_and), .holdoff(holdoff),
    .data_out(data_out), .armed(armed), .triggered(triggered),
    .trig_latched(trig_latched), .trig_time(trig_time)
  );

  // Narrow-counter instance on the same stimulus, used for saturation.
  trigger_engine #(.CH_W(8), .CNT_W(4)) dutSmall (
    .clk_PLL(clk_PLL), .reset(reset), .data_in(data_in), .arm(arm), .disarm(disarm),
    .rise_mask(rise_mask), .fall_mask(fall_mask), .level_mask(level_mask),
    .level_val(level_val), .combine_and(combine_and), .holdoff(holdoff[3:0]),
    .data_out(dataOutS), .armed(armedS), .triggered(triggeredS),
    .trig_latched(trigLatchedS), .trig_time(trigTimeS)
  );

  always #5 clk_PLL = ~clk_PLL;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_PLL);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tsExp(input logic [31:0] v);
    return TS ? v : 32'd0;
  endfunction

  initial begin
    reset = 1'b1; data_in = 8'hA5; arm = 1'b0; disarm = 1'b0;
    rise_mask = '0; fall_mask = '0; level_mask = '0; level_val = '0;
    combine_and = 1'b0; holdoff = '0;
    cyc(2);
    check("rst_data_out", data_out, 0);
    check("rst_armed", armed, 0);
    check("rst_triggered", triggered, 0);
    check("rst_latched", trig_latched, 0);
    check("rst_trig_time", trig_time, 0);
    reset = 1'b0; data_in = 8'h00;
    cyc(1);

    // Single rising edge, OR mode, no holdoff
    rise_mask = 8'h01; arm = 1'b1;
    cyc(1); arm = 1'b0;
    check("t1_armed", armed, 1);
    data_in = 8'h01;
    cyc(1);
    check("t1_data_out", data_out, 8'h01);
    check("t1_no_early_pulse", triggered, 0);
    cyc(1);
    check("t1_pulse", triggered, 1);
    check("t1_latched", trig_latched, 1);
    check("t1_armed_off", armed, 0);
    check("t1_trig_time", trig_time, tsExp(1));
    cyc(1);
    check("t1_pulse_end", triggered, 0);
    check("t1_still_latched", trig_latched, 1);

    // AND mode: bit1 rise qualified by bit0 low
    disarm = 1'b1; cyc(1); disarm = 1'b0;
    check("t2_idle", trig_latched, 0);
    combine_and = 1'b1; rise_mask = 8'h02; level_mask = 8'h01; level_val = 8'h00;
    data_in = 8'h01; arm = 1'b1;
    cyc(1); arm = 1'b0;
    data_in = 8'h03;
    cyc(2);
    check("t2_blocked_by_level", triggered, 0);
    check("t2_still_armed", armed, 1);
    data_in = 8'h00; cyc(1);
    data_in = 8'h02; cyc(1);
    check("t2_no_early_pulse", triggered, 0);
    cyc(1);
    check("t2_pulse", triggered, 1);
    check("t2_latched", trig_latched, 1);

    // Holdoff = 5: edge during holdoff ignored, later edge fires
    disarm = 1'b1; cyc(1); disarm = 1'b0;
    combine_and = 1'b0; rise_mask = 8'h01; level_mask = '0; data_in = 8'h00; holdoff = 16'd5;
    cyc(1);
    arm = 1'b1; cyc(1); arm = 1'b0;
    check("t3_in_holdoff", armed, 0);
    cyc(1); data_in = 8'h01;
    cyc(1); data_in = 8'h00;
    cyc(1);
    check("t3_ignored_edge", triggered, 0);
    cyc(1);
    check("t3_holdoff_last", armed, 0);
    cyc(1);
    check("t3_armed_after_5", armed, 1);
    cyc(2); data_in = 8'h01;
    cyc(1);
    check("t3_no_early_pulse", triggered, 0);
    cyc(1);
    check("t3_pulse", triggered, 1);
    check("t3_trig_time", trig_time, tsExp(3));

    // arm + disarm together while ARMED with a live match
    holdoff = 16'd0; arm = 1'b1; cyc(1); arm = 1'b0;
    check("t4_rearmed", armed, 1);
    check("t4_latch_cleared", trig_latched, 0);
    data_in = 8'h00; cyc(1);
    data_in = 8'h01; cyc(1);
    arm = 1'b1; disarm = 1'b1; cyc(1); arm = 1'b0; disarm = 1'b0;
    check("t4_disarm_armed", armed, 0);
    check("t4_disarm_pulse", triggered, 0);
    check("t4_disarm_latched", trig_latched, 0);
    cyc(1);
    check("t4_no_late_pulse", triggered, 0);

    // All masks zero never fires
    rise_mask = '0; combine_and = 1'b1; arm = 1'b1; cyc(1); arm = 1'b0;
    data_in = 8'h00; cyc(1); data_in = 8'hFF; cyc(2);
    check("t5_zero_mask_and", trig_latched, 0);
    combine_and = 1'b0; data_in = 8'h00; cyc(2);
    check("t5_zero_mask_or", armed, 1);

    // Async reset while FIRED, then no false edge on first sample
    rise_mask = 8'h01; data_in = 8'h01; cyc(1);
    data_in = 8'h00; cyc(1);
    data_in = 8'h01; cyc(2);
    check("t6_fired", trig_latched, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_latched", trig_latched, 0);
    check("t6_rst_data_out", data_out, 0);
    check("t6_rst_armed", armed, 0);
    check("t6_rst_trig_time", trig_time, 0);
    @(negedge clk_PLL);
    reset = 1'b0; data_in = 8'hFF; rise_mask = 8'hFF; arm = 1'b1;
    cyc(1); arm = 1'b0;
    check("t6_post_armed", armed, 1);
    check("t6_post_data", data_out, 8'hFF);
    cyc(1);
    check("t6_no_false_edge", triggered, 0);
    cyc(2);
    check("t6_no_false_latch", trig_latched, 0);

    // Timestamp: fire 10 cycles after ARMED entry, then saturation case
    disarm = 1'b1; rise_mask = 8'h01; data_in = 8'h00; cyc(1); disarm = 1'b0;
    cyc(1);
    arm = 1'b1; cyc(1); arm = 1'b0;
    cyc(9); data_in = 8'h01;
    cyc(2);
    check("t7_pulse", triggered, 1);
    check("t7_time10", trig_time, tsExp(10));
    check("t7_time10_small", trigTimeS, tsExp(10));
    disarm = 1'b1; data_in = 8'h00; cyc(1); disarm = 1'b0;
    arm = 1'b1; cyc(1); arm = 1'b0;
    cyc(19); data_in = 8'h01;
    cyc(2);
    check("t7_latched20", trigLatchedS, 1);
    check("t7_time20", trig_time, tsExp(20));
    check("t7_time_sat", trigTimeS, tsExp(15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
